// File: rtl/mult_control_n_pkg.sv
// mult_control_n_pkg
//   Shared definitions for the shift-add multiplier controller: FSM state
//   encodings, the default operand width and the CHECK-state operation
//   decoder used by the controller (unsigned or Booth radix-2).
//   Datapath and bench import this package so the encodings stay in step.
package mult_control_n_pkg;

  // 2-bit state encoding; values are visible to the datapath and bench.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ADDSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Operation chosen in CHECK; neither bit set means "shift only".
  typedef struct packed {
    logic ad;
    logic su;
  } check_op_t;

  // Decode the CHECK-state operation.
  //   booth=0 : M=1 adds, M=0 shifts.
  //   booth=1 : {M,Mm1}=01 adds, 10 subtracts, 00/11 shift only.
  function automatic check_op_t check_decode(input logic m, input logic mm1,
                                             input logic booth);
    check_op_t op;
    op.ad = 1'b0;
    op.su = 1'b0;
    if (booth) begin
      case ({m, mm1})
        2'b01:   op.ad = 1'b1;
        2'b10:   op.su = 1'b1;
        default: op    = '0;
      endcase
    end else begin
      op.ad = m;
    end
    return op;
  endfunction

endpackage

// File: rtl/mult_control_n_bit_counter.sv
// mult_bit_counter
//   Shift counter for the multiplier controller.
//   Ports:
//     Clk   in  1      clock
//     Rst   in  1      synchronous reset, active-high
//     clr   in  1      clear count to zero (operand load)
//     inc   in  1      increment count by one
//     count out CNT_W  current count
//     last  out 1      count == WIDTH-1
module mult_bit_counter
  import mult_control_n_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control_n.sv
// mult_control_n
//   Sequencer for a shift-add multiplier datapath of any operand WIDTH.
//   IDLE -> (Load) -> CHECK/ADDSH loop for WIDTH shifts -> DONE -> IDLE.
//   Optional feature macro: BOOTH_EN (adds Mm1 port and Booth radix-2
//   recoding; Su becomes live). Without it, Su is constant 0.
//   Ports:
//     Clk  in  clock            Rst  in  sync reset, active-high
//     St   in  start (level)    M    in  multiplier LSB
//     Mm1  in  previous shifted-out bit (BOOTH_EN only)
//     Idle/Done/Busy out  registered state flags
//     Load/Ad/Su/Sh  out  Mealy strobes to the datapath
//     Cnt  out  shifts completed (CNT_W bits)
module mult_control_n
  import mult_control_n_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             St,
  input  logic             M,
`ifdef BOOTH_EN
  input  logic             Mm1,
`endif
  output logic             Idle,
  output logic             Load,
  output logic             Ad,
  output logic             Su,
  output logic             Sh,
  output logic             Done,
  output logic             Busy,
  output logic [CNT_W-1:0] Cnt
);

`ifdef BOOTH_EN
  localparam logic BOOTH = 1'b1;
  logic mm1_s;
  assign mm1_s = Mm1;
`else
  localparam logic BOOTH = 1'b0;
  logic mm1_s;
  assign mm1_s = 1'b0;
`endif

  state_t           state_q;
  state_t           state_d;
  logic             idle_q;
  logic             busy_q;
  logic             done_q;
  logic             load_s;
  logic             ad_s;
  logic             su_s;
  logic             sh_s;
  logic             last_s;
  logic             inc_s;
  check_op_t        op_s;
  logic [CNT_W-1:0] count_s;

  // Next state and Mealy strobes; Rst suppresses every strobe.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    ad_s    = 1'b0;
    su_s    = 1'b0;
    sh_s    = 1'b0;
    op_s    = check_decode(M, mm1_s, BOOTH);
    if (Rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (St) begin
            load_s  = 1'b1;
            state_d = ST_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (op_s.ad) begin
            ad_s    = 1'b1;
            state_d = ST_ADDSH;
          end else if (op_s.su) begin
            su_s    = 1'b1;
            state_d = ST_ADDSH;
          end else begin
            sh_s    = 1'b1;
            state_d = last_s ? ST_DONE : ST_CHECK;
          end
        end
        ST_ADDSH: begin
          sh_s    = 1'b1;
          state_d = last_s ? ST_DONE : ST_CHECK;
        end
        ST_DONE: begin
          // Held St keeps us here; it must drop before a new start.
          state_d = St ? ST_DONE : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register and registered status flags decoded from next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
      busy_q  <= (state_d == ST_CHECK) || (state_d == ST_ADDSH);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // The final shift (taken with count at WIDTH-1) leaves the count parked
  // at WIDTH-1 instead of rolling over; only a Load clears it.
  assign inc_s = sh_s & ~last_s;

  mult_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (load_s),
    .inc   (inc_s),
    .count (count_s),
    .last  (last_s)
  );

  assign Idle = idle_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Load = load_s;
  assign Ad   = ad_s;
  assign Su   = su_s;
  assign Sh   = sh_s;
  assign Cnt  = count_s;

endmodule

// File: tb/tb_mult_control_n.sv
module tb_mult_control_n;
  import mult_control_n_pkg::*;

  localparam int unsigned WIDTH = DEFAULT_WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             Clk = 1'b0;
  logic             Rst;
  logic             St;
  logic             M;
`ifdef BOOTH_EN
  logic             Mm1;
`endif
  logic             Idle, Load, Ad, Su, Sh, Done, Busy;
  logic [CNT_W-1:0] Cnt;

  mult_control_n #(.WIDTH(WIDTH)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .St   (St),
    .M    (M),
`ifdef BOOTH_EN
    .Mm1  (Mm1),
`endif
    .Idle (Idle),
    .Load (Load),
    .Ad   (Ad),
    .Su   (Su),
    .Sh   (Sh),
    .Done (Done),
    .Busy (Busy),
    .Cnt  (Cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic             load;
    logic             ad;
    logic             su;
    logic             sh;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Direct status check request, consumed by the monitor this cycle.
  logic             chk_en = 1'b0;
  string            chk_name;
  logic             chk_idle, chk_busy, chk_done;
  logic [CNT_W-1:0] chk_cnt;
  logic             tb_end = 1'b0;

  task automatic tick();
    @(posedge Clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic drv(input logic st, input logic m, input logic mm1);
    St = st;
    M  = m;
`ifdef BOOTH_EN
    Mm1 = mm1;
`else
    if (mm1 === 1'bx) St = st;
`endif
  endtask

  task automatic ev(input logic load, input logic ad, input logic su,
                    input logic sh, input logic done, input int cnt);
    ev_t e;
    e.load = load;
    e.ad   = ad;
    e.su   = su;
    e.sh   = sh;
    e.done = done;
    e.cnt  = CNT_W'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic idle, input logic busy,
                     input logic done, input int cnt);
    chk_name = name;
    chk_idle = idle;
    chk_busy = busy;
    chk_done = done;
    chk_cnt  = CNT_W'(cnt);
    chk_en   = 1'b1;
  endtask

  // Monitor: direct status checks plus scoreboard pops on any strobe/Done.
  initial begin
    ev_t got;
    ev_t want;
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        n_vec++;
        if ({Idle, Busy, Done, Cnt, Load, Ad, Su, Sh} !==
            {chk_idle, chk_busy, chk_done, chk_cnt, 4'b0000}) begin
          n_err++;
          $display("FAIL %s: got Idle=%b Busy=%b Done=%b Cnt=%0d LASS=%b%b%b%b, want Idle=%b Busy=%b Done=%b Cnt=%0d LASS=0000",
                   chk_name, Idle, Busy, Done, Cnt, Load, Ad, Su, Sh,
                   chk_idle, chk_busy, chk_done, chk_cnt);
        end
      end
      if ((Load | Ad | Su | Sh | Done) === 1'b1) begin
        n_vec++;
        got = {Load, Ad, Su, Sh, Done, Cnt};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output at %0t: got L/A/S/Sh/D=%b%b%b%b%b Cnt=%0d, want none",
                   $time, Load, Ad, Su, Sh, Done, Cnt);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL event at %0t: got L/A/S/Sh/D=%b%b%b%b%b Cnt=%0d, want %b%b%b%b%b Cnt=%0d",
                     $time, got.load, got.ad, got.su, got.sh, got.done, got.cnt,
                     want.load, want.ad, want.su, want.sh, want.done, want.cnt);
          end
        end
      end
      if (tb_end) begin
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL leftover_events: got %0d outstanding, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, want finish before 20000");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations (WIDTH=4).
  initial begin
    Rst = 1'b1;
    drv(1'b1, 1'b0, 1'b0);
    @(posedge Clk);
    #1;

    // Reset held with St=1: no Load, idle state.
    chk("rst_c1", 1'b1, 1'b0, 1'b0, 0); tick;
    chk("rst_c2", 1'b1, 1'b0, 1'b0, 0); tick;

    // Release: Load in the same cycle; then M=0 for every check.
    Rst = 1'b0;
    drv(1'b1, 1'b0, 1'b0); ev(1, 0, 0, 0, 0, 0); tick;
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, i); tick;
    end
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 0, 1, 3); tick;
    chk("m0_back_idle", 1'b1, 1'b0, 1'b0, 3); tick;

    // M=1 for every check, St held high throughout (ignored while busy).
    drv(1'b1, 1'b1, 1'b0); ev(1, 0, 0, 0, 0, 3); tick;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 1'b0); ev(0, 1, 0, 0, 0, i); tick;
      drv(1'b1, 1'b1, 1'b0); ev(0, 0, 0, 1, 0, i); tick;
    end

    // St held in DONE: no retrigger; drop St -> IDLE next cycle.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b1, 1'b0); ev(0, 0, 0, 0, 1, 3); tick;
    end
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 0, 1, 3); tick;
    chk("done_release_idle", 1'b1, 1'b0, 1'b0, 3); tick;

    // Reset in ADDSH with Cnt=2: no Sh in the reset cycle.
    drv(1'b1, 1'b1, 1'b0); ev(1, 0, 0, 0, 0, 3); tick;
    drv(1'b0, 1'b1, 1'b0); ev(0, 1, 0, 0, 0, 0); tick;
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, 0); tick;
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, 1); tick;
    drv(1'b0, 1'b1, 1'b0); ev(0, 1, 0, 0, 0, 2); tick;
    Rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0);
    chk("rst_in_addsh", 1'b0, 1'b1, 1'b0, 2); tick;
    Rst = 1'b0;
    chk("after_mid_rst", 1'b1, 1'b0, 1'b0, 0); tick;

    // {M,Mm1} presented in CHECK: 10, 11, 01, 00.
    drv(1'b1, 1'b0, 1'b0); ev(1, 0, 0, 0, 0, 0); tick;
`ifdef BOOTH_EN
    drv(1'b0, 1'b1, 1'b0); ev(0, 0, 1, 0, 0, 0); tick;
    drv(1'b0, 1'b1, 1'b1); ev(0, 0, 0, 1, 0, 0); tick;
    drv(1'b0, 1'b1, 1'b1); ev(0, 0, 0, 1, 0, 1); tick;
    drv(1'b0, 1'b0, 1'b1); ev(0, 1, 0, 0, 0, 2); tick;
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, 2); tick;
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, 3); tick;
`else
    drv(1'b0, 1'b1, 1'b0); ev(0, 1, 0, 0, 0, 0); tick;
    drv(1'b0, 1'b1, 1'b1); ev(0, 0, 0, 1, 0, 0); tick;
    drv(1'b0, 1'b1, 1'b1); ev(0, 1, 0, 0, 0, 1); tick;
    drv(1'b0, 1'b0, 1'b1); ev(0, 0, 0, 1, 0, 1); tick;
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, 2); tick;
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 1, 0, 3); tick;
`endif
    drv(1'b0, 1'b0, 1'b0); ev(0, 0, 0, 0, 1, 3); tick;
    chk("recode_idle", 1'b1, 1'b0, 1'b0, 3); tick;

    tick;
    tb_end = 1'b1;
    tick;
    tick;
  end

endmodule
